// File: rtl/l1_mem_arbiter.sv
// Arbitrates the single main-memory block port between the L1 icache (reads)
// and the L1 dcache (reads and dirty write-backs), round-robin plus write-back lock.
module l1_mem_arbiter #(
    parameter int BLOCK_ADDR_W = 26,
    parameter int BLOCK_W      = 256
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    iRen,
    input  logic [BLOCK_ADDR_W-1:0] iBlockAddr,
    output logic                    iReadReady,
    output logic [BLOCK_W-1:0]      iDout,
    input  logic                    dRen,
    input  logic                    dWen,
    input  logic [BLOCK_ADDR_W-1:0] dBlockAddr,
    input  logic [BLOCK_W-1:0]      dDin,
    output logic                    dReadReady,
    output logic                    dWriteDone,
    output logic [BLOCK_W-1:0]      dDout,
    output logic                    memRen,
    output logic                    memWen,
    output logic [BLOCK_ADDR_W-1:0] BlockAddr,
    output logic [BLOCK_W-1:0]      memDin,
    input  logic                    memReadReady,
    input  logic                    memWriteDone,
    input  logic [BLOCK_W-1:0]      memDout
);

    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, DRAIN} state_t;

    state_t                  state, state_n;
    logic                    last_gnt, last_gnt_n;
    logic                    d_lock, d_lock_n;
    logic                    gnt_d, gnt_d_n;
    logic                    ren_n, wen_n;
    logic [BLOCK_ADDR_W-1:0] addr_n;
    logic [BLOCK_W-1:0]      din_n, idout_n, ddout_n;
    logic                    i_rdy_n, d_rdy_n, d_wdone_n;
    logic                    req_i, req_d, grant_i, grant_d, withdrawn;

    // A requester whose completion pulse is showing has not yet dropped its
    // level request; mask it so the stale level is not re-granted.
    assign req_i = iRen & ~iReadReady;
    assign req_d = (dRen | dWen) & ~dReadReady & ~dWriteDone;

    always_comb begin
        state_n    = state;
        last_gnt_n = last_gnt;
        d_lock_n   = d_lock;
        gnt_d_n    = gnt_d;
        ren_n      = memRen;
        wen_n      = memWen;
        addr_n     = BlockAddr;
        din_n      = memDin;
        idout_n    = iDout;
        ddout_n    = dDout;
        i_rdy_n    = 1'b0;
        d_rdy_n    = 1'b0;
        d_wdone_n  = 1'b0;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        withdrawn  = 1'b0;

        case (state)
            IDLE: begin
                // While dWriteDone shows, the dcache cannot yet raise its refill;
                // hold the bus so the lock is judged on its next request.
                if (!(d_lock && dWriteDone)) begin
                    if (d_lock && req_d) begin
                        grant_d = 1'b1;
                    end else begin
                        d_lock_n = 1'b0;
                        if (req_i && req_d) begin
                            grant_i = last_gnt;
                            grant_d = ~last_gnt;
                        end else begin
                            grant_i = req_i;
                            grant_d = req_d;
                        end
                    end
                end
                if (grant_i) begin
                    state_n = GNT_I;
                    gnt_d_n = 1'b0;
                    ren_n   = 1'b1;
                    addr_n  = iBlockAddr;
                end
                if (grant_d) begin
                    state_n = GNT_D;
                    gnt_d_n = 1'b1;
                    addr_n  = dBlockAddr;
                    if (dWen) begin
                        wen_n = 1'b1;
                        din_n = dDin;
                    end else begin
                        ren_n = 1'b1;
                    end
                end
            end
            GNT_I: begin
                if (memReadReady) begin
                    ren_n      = 1'b0;
                    state_n    = IDLE;
                    last_gnt_n = 1'b0;
                    d_lock_n   = 1'b0;
                    if (iRen) begin
                        i_rdy_n = 1'b1;
                        idout_n = memDout;
                    end
                end else if (!iRen) begin
                    state_n = DRAIN;
                end
            end
            GNT_D: begin
                withdrawn = memWen ? ~dWen : ~dRen;
                if (memWen && memWriteDone) begin
                    wen_n      = 1'b0;
                    state_n    = IDLE;
                    last_gnt_n = 1'b1;
                    if (!withdrawn) begin
                        d_wdone_n = 1'b1;
                        d_lock_n  = 1'b1;
                    end
                end else if (memRen && memReadReady) begin
                    ren_n      = 1'b0;
                    state_n    = IDLE;
                    last_gnt_n = 1'b1;
                    d_lock_n   = 1'b0;
                    if (!withdrawn) begin
                        d_rdy_n = 1'b1;
                        ddout_n = memDout;
                    end
                end else if (withdrawn) begin
                    state_n = DRAIN;
                end
            end
            DRAIN: begin
                if ((memRen && memReadReady) || (memWen && memWriteDone)) begin
                    ren_n      = 1'b0;
                    wen_n      = 1'b0;
                    state_n    = IDLE;
                    last_gnt_n = gnt_d;
                    d_lock_n   = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            last_gnt   <= 1'b1;
            d_lock     <= 1'b0;
            gnt_d      <= 1'b0;
            memRen     <= 1'b0;
            memWen     <= 1'b0;
            BlockAddr  <= '0;
            memDin     <= '0;
            iReadReady <= 1'b0;
            dReadReady <= 1'b0;
            dWriteDone <= 1'b0;
            iDout      <= '0;
            dDout      <= '0;
        end else begin
            state      <= state_n;
            last_gnt   <= last_gnt_n;
            d_lock     <= d_lock_n;
            gnt_d      <= gnt_d_n;
            memRen     <= ren_n;
            memWen     <= wen_n;
            BlockAddr  <= addr_n;
            memDin     <= din_n;
            iReadReady <= i_rdy_n;
            dReadReady <= d_rdy_n;
            dWriteDone <= d_wdone_n;
            iDout      <= idout_n;
            dDout      <= ddout_n;
        end
    end

endmodule

// File: tb/tb_l1_mem_arbiter.sv
// Bench for l1_mem_arbiter: directed scenarios, then randomized cache agents
// against a transaction-level reference of arbitration and memory contents.
module tb_l1_mem_arbiter;

    localparam int AW = 26;
    localparam int W  = 256;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          iRen = 1'b0, dRen = 1'b0, dWen = 1'b0;
    logic [AW-1:0] iBlockAddr = '0, dBlockAddr = '0;
    logic [W-1:0]  dDin = '0;
    logic          iReadReady, dReadReady, dWriteDone;
    logic [W-1:0]  iDout, dDout;
    logic          memRen, memWen;
    logic [AW-1:0] BlockAddr;
    logic [W-1:0]  memDin;
    logic          memReadReady, memWriteDone;
    logic [W-1:0]  memDout;

    int total = 0;
    int bad   = 0;

    l1_mem_arbiter #(.BLOCK_ADDR_W(AW), .BLOCK_W(W)) dut (
        .clock(clock), .reset(reset),
        .iRen(iRen), .iBlockAddr(iBlockAddr), .iReadReady(iReadReady), .iDout(iDout),
        .dRen(dRen), .dWen(dWen), .dBlockAddr(dBlockAddr), .dDin(dDin),
        .dReadReady(dReadReady), .dWriteDone(dWriteDone), .dDout(dDout),
        .memRen(memRen), .memWen(memWen), .BlockAddr(BlockAddr), .memDin(memDin),
        .memReadReady(memReadReady), .memWriteDone(memWriteDone), .memDout(memDout)
    );

    always #5 clock = ~clock;

    function automatic logic [W-1:0] pat(input logic [AW-1:0] a);
        return {8{6'h2A, a}};
    endfunction

    // Memory model: answers a strobe after a fixed or random latency.
    int             fixed_lat = 0;
    bit             stray_en  = 0;
    int             m_cnt = 0, m_lat = 1;
    logic [W-1:0]   mem_store [logic [AW-1:0]];

    initial begin
        memReadReady = 1'b0;
        memWriteDone = 1'b0;
        memDout      = '0;
        forever begin
            @(posedge clock); #1;
            memReadReady = 1'b0;
            memWriteDone = 1'b0;
            if (!reset || !(memRen || memWen)) begin
                m_cnt = 0;
                if (reset && stray_en && $urandom_range(7) == 0) begin
                    memReadReady = 1'b1;
                    memDout      = {8{$urandom()}};
                end
            end else begin
                m_cnt++;
                if (m_cnt == 1) m_lat = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 5));
                if (m_cnt == m_lat) begin
                    if (memWen) begin
                        memWriteDone = 1'b1;
                        mem_store[BlockAddr] = memDin;
                    end else begin
                        memReadReady = 1'b1;
                        memDout = mem_store.exists(BlockAddr) ? mem_store[BlockAddr] : pat(BlockAddr);
                    end
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock); #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; iRen = 0; dRen = 0; dWen = 0;
        iBlockAddr = '0; dBlockAddr = '0; dDin = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_memRen", memRen, 0);
        chk("rst_memWen", memWen, 0);
        chk("rst_addr", BlockAddr, 0);
        chk("rst_memDin", memDin, 0);
        chk("rst_irdy", iReadReady, 0);
        chk("rst_drdy", dReadReady, 0);
        chk("rst_dwd", dWriteDone, 0);
        chk("rst_iDout", iDout, 0);
        chk("rst_dDout", dDout, 0);
        tick();
        reset = 1'b1;
    endtask

    // Observe one memory transaction up to its completion pulse.
    task automatic xfer(output logic [AW-1:0] a, output logic wr, output logic [W-1:0] din,
                        output int idle, output int busy, output logic [2:0] kind);
        logic seen;
        seen = 0; a = '0; wr = 0; din = '0; idle = 0; busy = 0; kind = 3'b000;
        for (int n = 0; n < 40 && kind == 3'b000; n++) begin
            @(negedge clock);
            chk("no_overlap", memRen & memWen, 0);
            if (memRen || memWen) begin
                busy++;
                if (!seen) begin
                    seen = 1; a = BlockAddr; wr = memWen; din = memDin;
                end else begin
                    chk("addr_hold", BlockAddr, a);
                end
            end else if (!seen) begin
                idle++;
            end
            kind = {iReadReady, dReadReady, dWriteDone};
            if (kind != 3'b000) chk("turnaround", memRen | memWen, 0);
        end
        chk("xfer_done", kind != 3'b000, 1);
    endtask

    logic [AW-1:0] a;
    logic          wr;
    logic [W-1:0]  din;
    int            idle, busy;
    logic [2:0]    kind;
    logic [W-1:0]  wb_dat = {8{32'h1234_5678}};
    logic [W-1:0]  y_dat  = {8{32'hA5C3_0F19}};
    int            ren_cnt, irdy_cnt, mrr_cnt, found;

    // Reference state for the randomized phase.
    logic [W-1:0]  ref_mem [logic [AW-1:0]];
    bit            i_wait, i_got, d_got_w, d_got_r, exp_lock, last_side;
    bit            p_i, p_d, prev_strobe, side, exp_side;
    int            d_st, i_wcnt, d_wcnt;
    logic [AW-1:0] i_addr, d_addr;
    logic [W-1:0]  d_data;

    function automatic logic [AW-1:0] pool_addr();
        logic [2:0] k;
        k = 3'($urandom_range(7));
        return {1'b1, 22'h0, k};
    endfunction

    function automatic logic [W-1:0] exp_data(input logic [AW-1:0] ad);
        return ref_mem.exists(ad) ? ref_mem[ad] : pat(ad);
    endfunction

    initial begin
        // 1: single icache read, fixed latency 4
        do_reset();
        fixed_lat = 4;
        iRen = 1; iBlockAddr = 26'h0000010;
        xfer(a, wr, din, idle, busy, kind);
        chk("t1_addr", a, 26'h0000010);
        chk("t1_busy", busy, 4);
        chk("t1_kind", kind, 3'b100);
        chk("t1_iDout", iDout, pat(26'h0000010));
        chk("t1_dDout", dDout, 0);
        tick(); iRen = 0;
        @(negedge clock);
        chk("t1_pulse_len", iReadReady, 0);

        // 2: simultaneous requests after reset, then the swap
        do_reset();
        fixed_lat = 2;
        iRen = 1; iBlockAddr = 26'h11; dRen = 1; dBlockAddr = 26'h21;
        xfer(a, wr, din, idle, busy, kind);
        chk("t2_first", a, 26'h11);
        chk("t2_first_kind", kind, 3'b100);
        tick(); iRen = 0;
        xfer(a, wr, din, idle, busy, kind);
        chk("t2_second", a, 26'h21);
        chk("t2_second_idle", idle, 0);
        chk("t2_second_kind", kind, 3'b010);
        chk("t2_dDout", dDout, pat(26'h21));
        tick(); dRen = 0;
        iRen = 1; iBlockAddr = 26'h12;
        xfer(a, wr, din, idle, busy, kind);
        chk("t2_ialone", a, 26'h12);
        tick(); iRen = 0;
        tick(); iRen = 1; iBlockAddr = 26'h13; dRen = 1; dBlockAddr = 26'h22;
        xfer(a, wr, din, idle, busy, kind);
        chk("t2_swap", a, 26'h22);
        tick(); dRen = 0;
        xfer(a, wr, din, idle, busy, kind);
        chk("t2_swap_i", a, 26'h13);
        tick(); iRen = 0;

        // 3: write-back then refill beats a waiting icache
        do_reset();
        dWen = 1; dBlockAddr = 26'h20; dDin = wb_dat;
        tick(); iRen = 1; iBlockAddr = 26'h50;
        xfer(a, wr, din, idle, busy, kind);
        chk("t3_wb_addr", a, 26'h20);
        chk("t3_wb_dir", wr, 1);
        chk("t3_wb_data", din, wb_dat);
        chk("t3_wb_kind", kind, 3'b001);
        tick(); dWen = 0; dRen = 1; dBlockAddr = 26'h30;
        xfer(a, wr, din, idle, busy, kind);
        chk("t3_refill_addr", a, 26'h30);
        chk("t3_refill_dir", wr, 0);
        chk("t3_refill_kind", kind, 3'b010);
        chk("t3_refill_data", dDout, pat(26'h30));
        tick(); dRen = 0;
        xfer(a, wr, din, idle, busy, kind);
        chk("t3_i_addr", a, 26'h50);
        chk("t3_i_kind", kind, 3'b100);
        tick(); iRen = 0;

        // 4: dRen and dWen together -> write first, read as its own transaction
        dRen = 1; dWen = 1; dBlockAddr = 26'h40; dDin = y_dat;
        xfer(a, wr, din, idle, busy, kind);
        chk("t4_dir", wr, 1);
        chk("t4_kind", kind, 3'b001);
        tick(); dWen = 0;
        xfer(a, wr, din, idle, busy, kind);
        chk("t4_rd_dir", wr, 0);
        chk("t4_rd_addr", a, 26'h40);
        chk("t4_rd_gap", idle >= 1, 1);
        chk("t4_rd_kind", kind, 3'b010);
        chk("t4_rd_data", dDout, y_dat);
        tick(); dRen = 0;

        // 5: icache withdraws mid-grant -> drain without forwarding
        do_reset();
        fixed_lat = 6;
        iRen = 1; iBlockAddr = 26'h60;
        ren_cnt = 0; irdy_cnt = 0; mrr_cnt = 0;
        for (int k = 1; k <= 14; k++) begin
            tick();
            if (k == 3) iRen = 0;
            @(negedge clock);
            if (memRen) ren_cnt++;
            if (memRen && memReadReady) mrr_cnt++;
            if (iReadReady) irdy_cnt++;
        end
        chk("t5_ren_held", ren_cnt, 6);
        chk("t5_mrr_seen", mrr_cnt, 1);
        chk("t5_no_pulse", irdy_cnt, 0);
        fixed_lat = 2;
        tick(); iRen = 1; iBlockAddr = 26'h70;
        xfer(a, wr, din, idle, busy, kind);
        chk("t5_next_addr", a, 26'h70);
        chk("t5_next_kind", kind, 3'b100);
        chk("t5_next_data", iDout, pat(26'h70));
        tick(); iRen = 0;

        // 6: reset in the middle of a write-back
        do_reset();
        fixed_lat = 8;
        dWen = 1; dBlockAddr = 26'h80; dDin = wb_dat;
        tick(); iRen = 1; iBlockAddr = 26'h90;
        repeat (3) @(negedge clock);
        chk("t6_pre_wen", memWen, 1);
        #2 reset = 1'b0;
        #1;
        chk("t6_async_wen", memWen, 0);
        chk("t6_async_ren", memRen, 0);
        chk("t6_async_addr", BlockAddr, 0);
        chk("t6_async_din", memDin, 0);
        dWen = 0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        fixed_lat = 2;
        found = 0;
        for (int k = 0; k < 2 && found == 0; k++) begin
            @(negedge clock);
            if (memRen) found = 1;
        end
        chk("t6_regrant", found, 1);
        chk("t6_regrant_addr", BlockAddr, 26'h90);
        xfer(a, wr, din, idle, busy, kind);
        chk("t6_done_kind", kind, 3'b100);
        tick(); iRen = 0;

        // Randomized phase
        do_reset();
        fixed_lat = 0; stray_en = 1;
        i_wait = 0; i_got = 0; d_got_w = 0; d_got_r = 0; d_st = 0;
        exp_lock = 0; last_side = 1; p_i = 0; p_d = 0; prev_strobe = 0;
        i_wcnt = 0; d_wcnt = 0; i_addr = '0; d_addr = '0; d_data = '0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            tick();
            if (i_got) begin
                iRen = 0; i_wait = 0; i_got = 0;
            end else if (!i_wait && $urandom_range(3) == 0) begin
                i_wait = 1; i_wcnt = 0;
                i_addr = {1'b0, 25'($urandom())};
                iBlockAddr = i_addr; iRen = 1;
            end
            if (d_got_w) begin
                d_got_w = 0; dWen = 0; dRen = 1; d_st = 2; d_wcnt = 0;
                d_addr = pool_addr(); dBlockAddr = d_addr;
            end else if (d_got_r) begin
                d_got_r = 0; dRen = 0; d_st = 0;
            end else if (d_st == 0 && $urandom_range(3) == 0) begin
                d_addr = pool_addr(); dBlockAddr = d_addr; d_wcnt = 0;
                if ($urandom_range(1) == 1) begin
                    for (int k = 0; k < 8; k++) d_data[k*32 +: 32] = $urandom();
                    dDin = d_data; dWen = 1; d_st = 1;
                end else begin
                    dRen = 1; d_st = 2;
                end
            end
            if (i_wait) i_wcnt++;
            if (d_st != 0) d_wcnt++;

            @(negedge clock);
            chk("r_no_overlap", memRen & memWen, 0);
            chk("r_i_starve", i_wcnt < 100, 1);
            chk("r_d_starve", d_wcnt < 100, 1);
            if ((memRen || memWen) && !prev_strobe) begin
                side = BlockAddr[AW-1];
                if (exp_lock) exp_side = 1;
                else if (p_i && p_d) exp_side = ~last_side;
                else exp_side = p_d;
                chk("r_arb_side", side, exp_side);
                chk("r_arb_pending", side ? p_d : p_i, 1);
                chk("r_arb_addr", BlockAddr, side ? d_addr : i_addr);
                chk("r_arb_dir", memWen, side && d_st == 1);
                if (memWen) chk("r_wb_data", memDin, d_data);
            end
            if (iReadReady) begin
                chk("r_i_owner", i_wait, 1);
                chk("r_i_data", iDout, exp_data(i_addr));
                chk("r_i_gap", memRen | memWen, 0);
                last_side = 0; i_got = 1;
            end
            if (dReadReady) begin
                chk("r_dr_owner", d_st, 2);
                chk("r_dr_data", dDout, exp_data(d_addr));
                chk("r_dr_gap", memRen | memWen, 0);
                last_side = 1; exp_lock = 0; d_got_r = 1;
            end
            if (dWriteDone) begin
                chk("r_dw_owner", d_st, 1);
                chk("r_dw_gap", memRen | memWen, 0);
                ref_mem[d_addr] = d_data;
                last_side = 1; exp_lock = 1; d_got_w = 1;
            end
            p_i = iRen && !iReadReady;
            p_d = (dRen || dWen) && !dReadReady && !dWriteDone;
            prev_strobe = memRen || memWen;
        end

        stray_en = 0;
        tick(); iRen = 0; dRen = 0; dWen = 0;
        repeat (20) @(posedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
